// File: rtl/uart_rx_if.sv
// Byte handshake between uart_rx and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (
    output data_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry output register.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 1_152_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_i,
  uart_rx_if.master bus,
  output logic      busy_o,
  output logic      frame_err_o,
  output logic      overrun_o
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          rx_s;
  logic          valid_d;

  assign rx_s = sync_q[1];

  // Holding state as seen by a byte completing this cycle.
  assign valid_d = valid_q & ~bus.ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          // The detect cycle is the first clock of the start bit.
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= CNT_ONE;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_BIT) begin
            shreg_q   <= {rx_s, shreg_q[7:1]};
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q <= '0;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end else if (valid_d) begin
              overrun_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timing model plus
// directed and randomised line traffic.
module tb_uart_rx;

  localparam int CPB  = 86;
  localparam int HALF = 43;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i  = 1'b1;
  logic busy;
  logic fe;
  logic ov;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(1_152_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .bus        (bus),
    .busy_o     (busy),
    .frame_err_o(fe),
    .overrun_o  (ov)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         s;
    bit         good;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  ev_t  evq[$];
  win_t winq[$];
  logic [7:0] logq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Expected frame outcome: stop sample lands 2 sync clocks plus
  // HALF-1 plus nine bit-times after the line's falling edge.
  task automatic send(input logic [7:0] d, input bit ok,
                      input int hold, output int n);
    n = cyc + 1;
    evq.push_back(ev_t'{s: n + HALF + 1 + 9 * CPB,
                        good: ok, d: d});
    if (ok)
      winq.push_back(win_t'{lo: n + 2,
                            hi: n + HALF + 9 * CPB});
    else
      winq.push_back(win_t'{lo: n + 2,
                            hi: n + (10 + hold) * CPB + 1});
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(CPB);
    end
    rx_i = ok;
    tick(CPB);
    if (!ok) begin
      tick(hold * CPB);
      rx_i = 1'b1;
      tick(4);
    end
  endtask

  // Reference model and per-cycle compare.
  bit         valid_m = 1'b0;
  logic [7:0] data_m  = 8'h00;
  bit         exp_fe  = 1'b0;
  bit         exp_ov  = 1'b0;
  bit         prev_v  = 1'b0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         last_rise = -1;
  ev_t        ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_data", bus.data_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fe", fe, 0);
      chk("rst_ov", ov, 0);
      valid_m = 1'b0;
      data_m  = 8'h00;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
      prev_v  = 1'b0;
    end else begin
      chk("valid", bus.valid_o, valid_m);
      chk("data", bus.data_o, data_m);
      chk("busy", busy,
          winq.size() > 0 && cyc >= winq[0].lo &&
          cyc <= winq[0].hi);
      chk("frame_err", fe, exp_fe);
      chk("overrun", ov, exp_ov);
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (bus.valid_o && !prev_v) last_rise = cyc;
      prev_v = bus.valid_o;
      if (bus.valid_o && bus.ready_i)
        logq.push_back(bus.data_o);
      if (valid_m && bus.ready_i) valid_m = 1'b0;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (evq.size() > 0 && evq[0].s == cyc + 1) begin
        ev = evq.pop_front();
        if (!ev.good) exp_fe = 1'b1;
        else if (valid_m) exp_ov = 1'b1;
        else begin
          valid_m = 1'b1;
          data_m  = ev.d;
        end
      end
      if (winq.size() > 0 && cyc >= winq[0].hi)
        void'(winq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cyc %0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  bit   rnd_on = 1'b0;
  int   n;
  int   base;
  logic [7:0] hello [5];
  logic [7:0] a5;
  logic [7:0] d;

  initial begin
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    a5 = 8'hA5;
    bus.ready_i = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(10);

    // Single byte
    send(8'h41, 1'b1, 0, n);
    tick(20);
    chk("b41_cnt", logq.size(), 1);
    chk("b41_data", logq[0], 8'h41);
    chk("b41_rise", last_rise - n, 818);
    chk("b41_errs", fe_cnt + ov_cnt, 0);

    // Short glitch
    base = logq.size();
    n = cyc + 1;
    winq.push_back(win_t'{lo: n + 2, hi: n + HALF});
    rx_i = 1'b0;
    tick(20);
    rx_i = 1'b1;
    tick(HALF + 3 - 20);
    chk("glitch_busy", busy, 0);
    tick(50);
    chk("glitch_nobyte", logq.size(), base);
    chk("glitch_errs", fe_cnt + ov_cnt, 0);

    // Framing error with held break
    send(8'h55, 1'b0, 3, n);
    tick(20);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_busy", busy, 0);
    chk("brk_nobyte", logq.size(), base);

    // Overrun
    bus.ready_i = 1'b0;
    send(8'h11, 1'b1, 0, n);
    tick(30);
    send(8'h22, 1'b1, 0, n);
    tick(30);
    chk("ovr_cnt", ov_cnt, 1);
    chk("ovr_valid", bus.valid_o, 1);
    chk("ovr_data", bus.data_o, 8'h11);
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
    tick(2);
    chk("ovr_drain", bus.valid_o, 0);
    chk("ovr_byte", logq[logq.size()-1], 8'h11);

    // Back-to-back burst
    bus.ready_i = 1'b1;
    base = logq.size();
    for (int i = 0; i < 5; i++) send(hello[i], 1'b1, 0, n);
    tick(20);
    chk("hello_cnt", logq.size(), base + 5);
    for (int i = 0; i < 5; i++)
      chk("hello_byte", logq[base+i], hello[i]);
    chk("hello_errs", fe_cnt, 1);

    // Reset mid-frame with a held byte
    bus.ready_i = 1'b0;
    send(8'h99, 1'b1, 0, n);
    tick(20);
    n = cyc + 1;
    winq.push_back(win_t'{lo: n + 2,
                          hi: n + HALF + 9 * CPB});
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_i = a5[i];
      tick(CPB);
    end
    rx_i = a5[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    evq.delete();
    winq.delete();
    rx_i = 1'b1;
    tick(3);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_data", bus.data_o, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    bus.ready_i = 1'b1;
    base = logq.size();
    send(8'h3C, 1'b1, 0, n);
    tick(20);
    chk("post_rst_cnt", logq.size(), base + 1);
    chk("post_rst_byte", logq[base], 8'h3C);

    // Random traffic with random back-pressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          bus.ready_i = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join_none
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      send(d, $urandom_range(0, 7) != 0,
           $urandom_range(0, 2), n);
      if ($urandom_range(0, 1) == 1)
        tick($urandom_range(1, 200));
    end
    rnd_on = 1'b0;
    tick(2);
    bus.ready_i = 1'b1;
    tick(100);
    chk("end_valid", bus.valid_o, 0);
    chk("end_evq", evq.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
